// File: rtl/ram_pkg.sv
// Shared types and the byte-lane merge helper for the simple-dual-port RAM with clear engine.
package ram_pkg;

    typedef enum logic {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_state_t;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    // Widest word / lane vector the merge helper handles; instances zero-extend into these.
    localparam int unsigned RAM_IDX_W      = 8;
    localparam int unsigned RAM_MAX_DATA_W = 2 ** RAM_IDX_W;
    localparam int unsigned RAM_MAX_LANES  = 2 ** RAM_IDX_W;

    typedef logic [RAM_MAX_DATA_W-1:0] ram_word_t;
    typedef logic [RAM_MAX_LANES-1:0]  ram_be_t;

    function automatic ram_word_t be_merge(
        input ram_word_t   old_word,
        input ram_word_t   new_word,
        input ram_be_t     be,
        input int unsigned byte_w
    );
        ram_word_t merged;
        merged = old_word;
        for (int unsigned i = 0; i < RAM_MAX_DATA_W; i++) begin
            if (be[RAM_IDX_W'(i / byte_w)]) begin
                merged[RAM_IDX_W'(i)] = new_word[RAM_IDX_W'(i)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear engine: two-state FSM plus address counter that sweeps zeros over the whole array.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RAM_IDLE: begin
                if (clr_req) begin
                    state_d = RAM_CLEAR;
                    cnt_d   = '0;
                end
            end
            RAM_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = RAM_IDLE;
                end
            end
            default: state_d = RAM_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RST ? RAM_CLEAR : RAM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == RAM_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port RAM with byte enables, registered read + valid, selectable
// read-during-write policy, and a zeroing sweep after reset or on request.
module ram_sdp_be_clr
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned RDW_MODE     = RDW_READ_FIRST,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             clr_req,
    output logic                             busy
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH > RAM_MAX_DATA_W) begin : g_bad_width
        $error("ram_sdp_be_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH and at most RAM_MAX_DATA_W");
    end

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_LANES-1:0]  be
    );
        ram_word_t merged;
        merged = be_merge(ram_word_t'(old_word), ram_word_t'(new_word), ram_be_t'(be), BYTE_WIDTH);
        return DATA_WIDTH'(merged);
    endfunction

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clear_seq #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .CLEAR_ON_RST(CLEAR_ON_RST)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_LANES-1:0]  mem_wbe;

    // The sweep owns the write port while busy; a cycle with rst high never writes.
    always_comb begin
        if (busy) begin
            mem_we    = clr_we & ~rst;
            mem_waddr = clr_addr;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else begin
            mem_we    = wr_en & ~rst;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
            mem_wbe   = wr_be;
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; zeroing is the sweep's job.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= merge_word(mem[mem_waddr], mem_wdata, mem_wbe);
        end
    end

    logic                  rd_accept;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q;

    assign rd_accept = rd_en & ~busy;
    assign rd_hit    = (RDW_MODE == RDW_WRITE_FIRST) && mem_we && !busy && (wr_addr == rd_addr);

    always_comb begin
        rd_word   = rd_hit ? merge_word(mem[rd_addr], wr_data, wr_be) : mem[rd_addr];
        rd_data_d = rd_accept ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_accept;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Bench for ram_sdp_be_clr: two instances (read-first/clear-on-reset and
// write-first/no-clear-on-reset) driven in lockstep against a behavioural model.
module tb_ram_sdp_be_clr;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int NL    = DW / BW;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_a, rst_b, clr_req, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [NL-1:0] wr_be;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b, busy_a, busy_b;

    always #5 clk = ~clk;

    ram_sdp_be_clr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RDW_MODE(0), .CLEAR_ON_RST(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .clr_req(clr_req), .busy(busy_a)
    );

    ram_sdp_be_clr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RDW_MODE(1), .CLEAR_ON_RST(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .clr_req(clr_req), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: index 0 = dut_a (read-first, clear on reset), 1 = dut_b (write-first).
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_left [2];
    logic [DW-1:0] m_rd_data [2];
    logic          m_rd_valid [2];

    function automatic logic [DW-1:0] m_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                              input logic [NL-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NL; b++) begin
            if (be[b]) r[b*BW +: BW] = new_w[b*BW +: BW];
        end
        return r;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic          r;
            logic [DW-1:0] word;
            r = (d == 0) ? rst_a : rst_b;
            if (r) begin
                m_rd_data[d]  = '0;
                m_rd_valid[d] = 1'b0;
                m_left[d]     = (d == 0) ? DEPTH : 0;
            end else if (m_left[d] > 0) begin
                m_mem[d][DEPTH - m_left[d]] = '0;
                m_left[d]     = m_left[d] - 1;
                m_rd_valid[d] = 1'b0;
            end else begin
                m_rd_valid[d] = rd_en;
                if (rd_en) begin
                    word = m_mem[d][rd_addr];
                    if (d == 1 && wr_en && wr_addr == rd_addr) word = m_merge(word, wr_data, wr_be);
                    m_rd_data[d] = word;
                end
                if (wr_en) m_mem[d][wr_addr] = m_merge(m_mem[d][wr_addr], wr_data, wr_be);
                if (clr_req) m_left[d] = DEPTH;
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("sb_busy_a",  32'(busy_a),     32'(m_left[0] > 0));
        check("sb_valid_a", 32'(rd_valid_a), 32'(m_rd_valid[0]));
        check("sb_data_a",  rd_data_a,       m_rd_data[0]);
        check("sb_busy_b",  32'(busy_b),     32'(m_left[1] > 0));
        check("sb_valid_b", 32'(rd_valid_b), 32'(m_rd_valid[1]));
        check("sb_data_b",  rd_data_b,       m_rd_data[1]);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_a && n < 64) begin
            n++;
            cycle();
        end
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = base + DW'(i); wr_be = '1;
            cycle();
        end
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic [NL-1:0] wr_be;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          exp_valid;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[1]  = '{1'b1, 4'd3, 32'h11223344, 4'h5, 1'b0, 4'd0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[2]  = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd3, 1'b1, 32'hAA22CC44, 32'hAA22CC44};
        vecs[3]  = '{1'b1, 4'd5, 32'h12345678, 4'hF, 1'b0, 4'd0, 1'b0, 32'hAA22CC44, 32'hAA22CC44};
        vecs[4]  = '{1'b1, 4'd5, 32'hFFFFFFFF, 4'h3, 1'b1, 4'd5, 1'b1, 32'h12345678, 32'h1234FFFF};
        vecs[5]  = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd5, 1'b1, 32'h1234FFFF, 32'h1234FFFF};
        vecs[6]  = '{1'b1, 4'd1, 32'h0A0B0C01, 4'hF, 1'b0, 4'd0, 1'b0, 32'h1234FFFF, 32'h1234FFFF};
        vecs[7]  = '{1'b1, 4'd2, 32'h0A0B0C02, 4'hF, 1'b0, 4'd0, 1'b0, 32'h1234FFFF, 32'h1234FFFF};
        vecs[8]  = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd1, 1'b1, 32'h0A0B0C01, 32'h0A0B0C01};
        vecs[9]  = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd2, 1'b1, 32'h0A0B0C02, 32'h0A0B0C02};
        vecs[10] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd3, 1'b1, 32'hAA22CC44, 32'hAA22CC44};
        vecs[11] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd1, 1'b1, 32'h0A0B0C01, 32'h0A0B0C01};
        vecs[12] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b0, 4'd0, 1'b0, 32'h0A0B0C01, 32'h0A0B0C01};
        vecs[13] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b0, 4'd0, 1'b0, 32'h0A0B0C01, 32'h0A0B0C01};
        vecs[14] = '{1'b1, 4'd6, 32'h66666666, 4'hF, 1'b1, 4'd1, 1'b1, 32'h0A0B0C01, 32'h0A0B0C01};
        vecs[15] = '{1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd3, 1'b1, 32'hAA22CC44, 32'hAA22CC44};
        vecs[16] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd3, 1'b1, 32'hAA22CC44, 32'hAA22CC44};

        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_rd_data[d] = '0; m_rd_valid[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
        end

        // Reset both, then re-reset dut_a while dut_b takes a clear request so the two sweep in lockstep.
        idle_inputs();
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        cycle();
        rst_b = 1'b0; clr_req = 1'b1;
        cycle();
        rst_a = 1'b0; clr_req = 1'b0;

        // Post-reset sweep length and zero image.
        wait_idle(n);
        check("reset_sweep_len", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            cycle();
            check($sformatf("zero_valid_a%0d", i), 32'(rd_valid_a), 32'd1);
            check($sformatf("zero_data_a%0d", i), rd_data_a, 32'h0);
            check($sformatf("zero_data_b%0d", i), rd_data_b, 32'h0);
        end
        rd_en = 1'b0;

        // Byte enables, read-during-write in both modes, back-to-back reads, be=0 no-op.
        for (int v = 0; v < 17; v++) begin
            wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
            wr_be = vecs[v].wr_be; rd_en = vecs[v].rd_en; rd_addr = vecs[v].rd_addr;
            cycle();
            check($sformatf("vec%0d_valid_a", v), 32'(rd_valid_a), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_valid_b", v), 32'(rd_valid_b), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data_a", v), rd_data_a, vecs[v].exp_a);
            check($sformatf("vec%0d_data_b", v), rd_data_b, vecs[v].exp_b);
        end
        idle_inputs();

        // Randomized traffic with occasional clear requests, scored against the model every cycle.
        for (int k = 0; k < 300; k++) begin
            clr_req = ($urandom_range(0, 63) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = $urandom;
            wr_be   = NL'($urandom_range(0, 15));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        idle_inputs();
        wait_idle(n);

        // Clear request with user accesses attempted throughout the sweep.
        fill(32'hDEAD0000);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h22222222; wr_be = '1;
        rd_en = 1'b1; rd_addr = 4'd2;
        wait_idle(n);
        check("req_sweep_len", 32'(n), 32'd16);
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            cycle();
            check($sformatf("clr_valid_a%0d", i), 32'(rd_valid_a), 32'd1);
            check($sformatf("clr_data_a%0d", i), rd_data_a, 32'h0);
            check($sformatf("clr_data_b%0d", i), rd_data_b, 32'h0);
        end
        rd_en = 1'b0;

        // Reset landing on sweep cycle 7.
        fill(32'hBEEF0000);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (7) cycle();
        rst_a = 1'b1; rst_b = 1'b1;
        cycle();
        rst_a = 1'b0; rst_b = 1'b0;
        check("midrst_busy_a", 32'(busy_a), 32'd1);
        check("midrst_busy_b", 32'(busy_b), 32'd0);
        wait_idle(n);
        check("midrst_sweep_len", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            cycle();
            check($sformatf("midrst_data_a%0d", i), rd_data_a, 32'h0);
            check($sformatf("midrst_data_b%0d", i), rd_data_b, (i < 7) ? 32'h0 : 32'hBEEF0000 + 32'(i));
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
